// File: rtl/gasid_feature_loader.sv
// gasid_feature_loader: assembles BUS_BITS beats into one classifier feature frame with framing checks
module gasid_feature_loader #(
  parameter int FEAT_CNT  = 128,
  parameter int FEAT_BITS = 4,
  parameter int BUS_BITS  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BUS_BITS-1:0]           in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          features_valid,
  input  logic                          features_ready,
  output logic                          frame_err,
  output logic [15:0]                   frame_cnt
);
  localparam int FW    = FEAT_CNT*FEAT_BITS;
  localparam int BEATS = FW/BUS_BITS;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic acc, at_end, done, err;
  assign in_ready       = rst_n && state == FILL;
  assign features_valid = state == HOLD;
  always_comb begin
    acc      = in_valid && in_ready;
    at_end   = cnt == CW'(BEATS-1);
    done     = acc && at_end && in_last;
    err      = acc && (at_end != in_last);
    state_nx = state == FILL ? (done ? HOLD : FILL) : (features_ready ? FILL : HOLD);
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= FILL;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt       <= '0;
      features  <= '0;
      frame_err <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      frame_err <= err;
      if (acc) begin
        features[BUS_BITS*cnt +: BUS_BITS] <= in_data;
        cnt <= (done || err) ? '0 : cnt + CW'(1);
      end
      if (state == HOLD && features_ready) frame_cnt <= frame_cnt + 16'd1;
    end
endmodule

// File: tb/tb_gasid_feature_loader.sv
// tb_gasid_feature_loader: directed checks of frame assembly, backpressure, framing errors and reset
module tb_gasid_feature_loader;
  logic clk = 0, rst_n = 0;
  logic [31:0] in_data = 0;
  logic in_valid = 0, in_last = 0, in_ready;
  logic [511:0] features;
  logic features_valid, features_ready = 0, frame_err;
  logic [15:0] frame_cnt;
  int total = 0, bad = 0;
  logic [511:0] f;
  int ec;
  gasid_feature_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .features(features), .features_valid(features_valid),
    .features_ready(features_ready), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send_beat(input logic [31:0] d, input logic l, input bit gaps);
    int n = 0;
    if (gaps && $urandom_range(1) == 1) begin
      in_valid = 0;
      in_data  = $urandom;
      in_last  = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; in_data = $urandom; in_last = 0;
  endtask
  task automatic send_frame(input logic [511:0] fr, input int n, input bit l, input bit gaps);
    for (int k = 0; k < n; k++) send_beat(fr[k*32 +: 32], l && k == n-1, gaps);
  endtask
  task automatic rand_frame(output logic [511:0] fr);
    for (int k = 0; k < 16; k++) fr[k*32 +: 32] = $urandom;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_fv", features_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_feat", features, 0);
    rst_n = 1;
    #1 chk("ready_after_rst", in_ready, 1);
    features_ready = 1;
    f = {16{32'h76543210}};
    send_frame(f, 15, 0, 0);
    chk("b2b_fv_pre", features_valid, 0);
    send_beat(f[511:480], 1, 0);
    chk("b2b_fv", features_valid, 1);
    chk("b2b_feat", features, f);
    chk("b2b_ready_hold", in_ready, 0);
    @(posedge clk); #1;
    chk("b2b_fv_drop", features_valid, 0);
    chk("b2b_cnt", frame_cnt, 1);
    chk("b2b_ready_fill", in_ready, 1);
    features_ready = 0;
    for (int k = 0; k < 16; k++) f[k*32 +: 32] = {8{4'(k)}} ^ 32'hA5A5_0F0F;
    send_frame(f, 16, 1, 0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_fv", features_valid, 1);
      chk("bp_feat", features, f);
      chk("bp_ready", in_ready, 0);
      chk("bp_cnt", frame_cnt, 1);
      @(posedge clk); #1;
    end
    features_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_fv", features_valid, 0);
    chk("bp_release_cnt", frame_cnt, 2);
    rand_frame(f);
    send_frame(f, 6, 1, 0);
    chk("early_err", frame_err, 1);
    chk("early_fv", features_valid, 0);
    @(posedge clk); #1;
    chk("early_err_pulse", frame_err, 0);
    chk("early_fv2", features_valid, 0);
    rand_frame(f);
    send_frame(f, 16, 1, 0);
    chk("early_next_fv", features_valid, 1);
    chk("early_next_feat", features, f);
    @(posedge clk); #1;
    chk("early_next_cnt", frame_cnt, 3);
    rand_frame(f);
    send_frame(f, 16, 0, 0);
    chk("miss_err", frame_err, 1);
    chk("miss_fv", features_valid, 0);
    chk("miss_cnt", frame_cnt, 3);
    @(posedge clk); #1;
    chk("miss_err_pulse", frame_err, 0);
    ec = 3;
    repeat (20) begin
      rand_frame(f);
      send_frame(f, 16, 1, 1);
      chk("gap_fv", features_valid, 1);
      chk("gap_feat", features, f);
      @(posedge clk); #1;
      ec++;
    end
    chk("gap_cnt", frame_cnt, 16'(ec));
    rand_frame(f);
    send_frame(f, 8, 0, 0);
    in_valid = 1; in_data = $urandom; in_last = 0; rst_n = 0;
    @(posedge clk); #1;
    chk("rst_mid_fv", features_valid, 0);
    chk("rst_mid_err", frame_err, 0);
    chk("rst_mid_cnt", frame_cnt, 0);
    chk("rst_mid_feat", features, 0);
    chk("rst_mid_ready", in_ready, 0);
    in_valid = 0; rst_n = 1;
    @(posedge clk); #1;
    chk("rst_mid_noerr", frame_err, 0);
    features_ready = 0;
    send_frame(f, 16, 1, 0);
    chk("hold_fv", features_valid, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("rst_hold_fv", features_valid, 0);
    chk("rst_hold_feat", features, 0);
    chk("rst_hold_cnt", frame_cnt, 0);
    chk("rst_hold_err", frame_err, 0);
    rst_n = 1; features_ready = 1;
    @(posedge clk); #1;
    rand_frame(f);
    send_frame(f, 16, 1, 0);
    chk("post_rst_fv", features_valid, 1);
    chk("post_rst_feat", features, f);
    @(posedge clk); #1;
    chk("post_rst_cnt", frame_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gasid_feature_loader.md
GASID_FEATURE_LOADER -- requirements
Module: gasid_feature_loader

Interface
REQ-001 SHALL have parameter FEAT_CNT, default 128: number of features per frame.
REQ-002 SHALL have parameter FEAT_BITS, default 4: unsigned bits per feature.
REQ-003 SHALL have parameter BUS_BITS, default 32: input beat width; FEAT_CNT*FEAT_BITS is an integer multiple of BUS_BITS.
REQ-004 SHALL derive BEATS = FEAT_CNT*FEAT_BITS/BUS_BITS, which is 16 at the defaults.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port in_data, input, BUS_BITS: one feature beat, packed with the lowest feature index in the LSBs.
REQ-008 SHALL have port in_valid, input, 1: in_data is valid.
REQ-009 SHALL have port in_last, input, 1: marks the final beat of a frame.
REQ-010 SHALL have port in_ready, output, 1: loader accepts a beat.
REQ-011 SHALL have port features, output, FEAT_CNT*FEAT_BITS: assembled frame, laid out exactly as the classifier's features input.
REQ-012 SHALL have port features_valid, output, 1: features holds a complete frame.
REQ-013 SHALL have port features_ready, input, 1: downstream consumes the frame.
REQ-014 SHALL have port frame_err, output, 1: one-cycle pulse on a framing error.
REQ-015 SHALL have port frame_cnt, output, 16: count of frames delivered.

Function
REQ-016 SHALL define a beat as accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 SHALL use states FILL and HOLD; in_ready SHALL equal 1 only in FILL with rst_n=1.
REQ-018 SHALL hold a beat counter, width clog2(BEATS); the accepted beat k SHALL be written to features[k*BUS_BITS +: BUS_BITS], after which the counter increments.
REQ-019 SHALL treat a beat accepted with counter=BEATS-1 and in_last=1 as the final beat: counter goes to 0, state goes to HOLD, and features_valid=1 from the next cycle.
REQ-020 SHALL give a latency of exactly 1 cycle from acceptance of the final beat to features_valid=1.
REQ-021 SHALL keep features stable and features_valid=1 while in HOLD until features_ready=1 is sampled.
REQ-022 SHALL, on the edge where HOLD sees features_ready=1, set features_valid=0, increment frame_cnt, and return to FILL; in_ready is 0 in that cycle, with no same-cycle refill.
REQ-023 SHALL wrap frame_cnt modulo 2^16 (0xFFFF -> 0x0000).
REQ-024 SHALL handle an early-last error (in_last=1 on an accepted beat with counter<BEATS-1) as follows: frame_err=1 for the next cycle, counter=0, state stays FILL, frame discarded.
REQ-025 SHALL handle a missing-last error (in_last=0 on an accepted beat with counter=BEATS-1) identically to REQ-024.
REQ-026 SHALL leave features contents unspecified after a discarded frame; features_valid SHALL NOT assert for a discarded frame and frame_cnt SHALL NOT increment.
REQ-027 SHALL treat in_valid=0 cycles mid-frame as stalls that change no state and impose no timeout.
REQ-028 SHALL ignore in_data and in_last when no beat is accepted.
REQ-029 SHALL drive frame_err, features_valid and frame_cnt from registers only (no combinational path from inputs).

Reset
REQ-030 SHALL, while rst_n=0 at a rising edge, set state=FILL, counter=0, features=0, features_valid=0, frame_err=0, frame_cnt=0.
REQ-031 SHALL hold in_ready=0 while rst_n=0.
REQ-032 SHALL, on reset mid-frame or in HOLD, discard the partial or pending frame with no frame_err.
REQ-033 SHALL make the first beat after reset release beat 0.

Verification
REQ-034 SHALL cover back-to-back frame: 16 beats of 0x76543210, last on beat 15, features_ready=1 -> features_valid one cycle after beat 15, features = 128 nibbles repeating 0..7, frame_cnt=1.
REQ-035 SHALL cover backpressure: features_ready=0 for 10 cycles after a frame -> features_valid stays 1, features stable, in_ready=0 throughout, frame_cnt unchanged until release.
REQ-036 SHALL cover early last: in_last on beat 5 -> single-cycle frame_err, no features_valid; the next 16-beat clean frame is delivered correctly.
REQ-037 SHALL cover missing last: 16 beats with in_last=0 -> frame_err on the cycle after beat 15, counter=0, frame_cnt unchanged.
REQ-038 SHALL cover random in_valid gaps (about 50%) over 20 frames -> every frame bit-exact against the model, frame_cnt=20.
REQ-039 SHALL cover rst_n=0 asserted on beat 8 and in HOLD -> all outputs at reset values next cycle, no frame_err, and a following frame delivered correctly.
